// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg -- shared definitions for the FIFO write arbiters.
//
// Contents:
//   ST_IDLE / ST_GRANT  one-bit FSM state encoding (nobody owns / one owner)
//   BEAT_CNT_W          width of the per-grant beat counter
//   MAX_NREQ            largest requester count the helpers support
//   onehot_to_idx()     one-hot (up to MAX_NREQ bits) to binary index
// ---------------------------------------------------------------------------
package arb_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam int BEAT_CNT_W = 4;
  localparam int MAX_NREQ   = 8;

  // OR-encoder: valid for one-hot or all-zero input (zero maps to index 0).
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_NREQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (oh[i]) begin
        idx = idx | 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick -- combinational round-robin search.
//
// Returns the first requesting index searched upward from (last+1) mod NREQ,
// wrapping around. The index 'last' itself is checked last, so it only wins
// when it is the sole requester.
//
// Ports:
//   req    [NREQ-1:0]  request vector
//   last   [IDXW-1:0]  most recent owner index
//   pick   [NREQ-1:0]  one-hot winner (zero when no request)
//   valid              at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int  NREQ = 4,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last,
  output logic [NREQ-1:0] pick,
  output logic            valid
);

  logic [IDXW-1:0]   start;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot_lo;
  logic [NREQ-1:0]   low_oh;

  assign start = (last == IDXW'(NREQ - 1)) ? '0 : last + IDXW'(1);

  // Rotate so the search origin sits at bit 0, isolate the lowest set bit,
  // then rotate the one-hot result back into place.
  assign dbl    = {req, req};
  assign rot_lo = NREQ'(dbl >> start);
  assign low_oh = rot_lo & (~rot_lo + NREQ'(1));
  assign pick   = NREQ'(({low_oh, low_oh} << start) >> NREQ);
  assign valid  = |req;

endmodule

// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter -- round-robin arbiter granting NREQ requesters bursts
// of up to MAX_BURST beats into one shared FIFO write port. Holds no storage.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   req            per-requester write request
//   data           requester i data on [i*WIDTH +: WIDTH]
//   fifo_full      full flag from the shared FIFO (stalls the burst)
//   grant          registered one-hot (or zero) ownership vector
//   ack            combinational beat-accepted strobe per requester
//   fifo_write_en  combinational FIFO write enable (= |ack)
//   fifo_data_in   combinational FIFO write data (0 when nobody owns)
//   busy           registered, high while an owner exists
// ---------------------------------------------------------------------------
module fifo_write_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  input  logic                  fifo_full,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       ack,
  output logic                  fifo_write_en,
  output logic [WIDTH-1:0]      fifo_data_in,
  output logic                  busy
);

  localparam int IDXW = $clog2(NREQ);

  logic [0:0]            state_reg, state_next;
  logic [NREQ-1:0]       grant_reg, grant_next;
  logic [BEAT_CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
  logic [IDXW-1:0]       last_reg, last_next;

  logic [NREQ-1:0]       pick;
  logic                  pick_valid;
  logic [IDXW-1:0]       pick_idx;
  logic                  owner_active;
  logic                  burst_last;
  logic                  release_now;
  logic [WIDTH-1:0]      masked_data [NREQ];

  // last_reg always holds the current owner while granted, so the same
  // search serves both the IDLE->GRANT decision and the hand-over on release.
  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req   (req),
    .last  (last_reg),
    .pick  (pick),
    .valid (pick_valid)
  );

  assign pick_idx = IDXW'(onehot_to_idx(MAX_NREQ'(pick)));

  // ---------------- combinational write path ----------------
  assign ack           = grant_reg & req & {NREQ{~fifo_full}};
  assign fifo_write_en = |ack;
  assign grant         = grant_reg;
  assign busy          = (state_reg == ST_GRANT);

  // AND-OR mux: grant is one-hot or zero, so zero grant yields zero data.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_data_mux
    assign masked_data[gi] = grant_reg[gi] ? data[gi*WIDTH +: WIDTH] : '0;
  end

  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      fifo_data_in = fifo_data_in | masked_data[i];
    end
  end

  // ---------------- release decision ----------------
  assign owner_active = |(grant_reg & req);
  assign burst_last   = fifo_write_en &&
                        (beat_cnt_reg == BEAT_CNT_W'(MAX_BURST - 1));
  assign release_now  = (state_reg == ST_GRANT) && (!owner_active || burst_last);

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    beat_cnt_next = beat_cnt_reg;
    last_next     = last_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          state_next    = ST_GRANT;
          grant_next    = pick;
          beat_cnt_next = '0;
          last_next     = pick_idx;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          if (pick_valid) begin
            // Direct hand-over, no idle bubble.
            grant_next    = pick;
            beat_cnt_next = '0;
            last_next     = pick_idx;
          end else begin
            // last_reg keeps the released owner.
            state_next    = ST_IDLE;
            grant_next    = '0;
            beat_cnt_next = '0;
          end
        end else if (fifo_write_en) begin
          beat_cnt_next = beat_cnt_reg + BEAT_CNT_W'(1);
        end
      end
      default: begin
        state_next    = ST_IDLE;
        grant_next    = '0;
        beat_cnt_next = '0;
      end
    endcase
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      grant_reg    <= '0;
      beat_cnt_reg <= '0;
      last_reg     <= IDXW'(NREQ - 1);
    end else begin
      state_reg    <= state_next;
      grant_reg    <= grant_next;
      beat_cnt_reg <= beat_cnt_next;
      last_reg     <= last_next;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_write_arbiter -- directed self-checking bench for fifo_write_arbiter
// (WIDTH=8, NREQ=4, MAX_BURST=4). Each step drives inputs just after a rising
// edge, pushes the expected FIFO write into a queue and checks the outputs
// on the falling edge; a monitor pops the queue on every real FIFO write.
// ---------------------------------------------------------------------------
module tb_fifo_write_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int MB = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data = '0;
  logic           fifo_full = 1'b0;
  logic [N-1:0]   grant;
  logic [N-1:0]   ack;
  logic           fifo_write_en;
  logic [W-1:0]   fifo_data_in;
  logic           busy;

  int vectors = 0;
  int miscompares = 0;
  int stepno = 0;
  logic [15:0] exp_q [$];
  int exp_cnt [N];
  int wr_cnt  [N];
  int ack_cnt [N];
  int mon_owner;
  logic [15:0] mon_exp;

  fifo_write_arbiter #(.WIDTH(W), .NREQ(N), .MAX_BURST(MB)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req           (req),
    .data          (data),
    .fifo_full     (fifo_full),
    .grant         (grant),
    .ack           (ack),
    .fifo_write_en (fifo_write_en),
    .fifo_data_in  (fifo_data_in),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (step %0d)", tag, obs, exp, stepno);
    end
  endtask

  // One clock of stimulus plus the outputs expected in that cycle.
  task automatic step(input logic [N-1:0] r, input logic f,
                      input logic [N-1:0] eg, input logic [N-1:0] ea);
    logic [W-1:0] exp_data;
    @(posedge clk);
    #1;
    stepno++;
    req       = r;
    fifo_full = f;
    for (int i = 0; i < N; i++) begin
      data[i*W +: W] = 8'(i * 16 + (stepno % 16));
    end
    exp_data = '0;
    for (int i = 0; i < N; i++) begin
      if (eg[i]) exp_data = data[i*W +: W];
    end
    for (int i = 0; i < N; i++) begin
      if (ea[i]) begin
        exp_q.push_back({8'(i), exp_data});
        exp_cnt[i]++;
      end
    end
    @(negedge clk);
    $display("step %0d req=%b full=%b grant=%b ack=%b wen=%b din=%h busy=%b",
             stepno, req, fifo_full, grant, ack, fifo_write_en, fifo_data_in, busy);
    chk("grant", 32'(grant), 32'(eg));
    chk("ack", 32'(ack), 32'(ea));
    chk("write_en", 32'(fifo_write_en), 32'(|ea));
    chk("data_in", 32'(fifo_data_in), 32'(exp_data));
    chk("busy", 32'(busy), 32'(|eg));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    req     = '0;
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
  endtask

  // Write monitor / scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      vectors++;
      assert ($countones(grant) <= 1) else begin
        miscompares++;
        $error("FAIL onehot: observed grant %b expected at most one bit", grant);
      end
      for (int i = 0; i < N; i++) begin
        if (ack[i]) ack_cnt[i]++;
      end
      if (fifo_write_en) begin
        mon_owner = 0;
        for (int i = 0; i < N; i++) begin
          if (grant[i]) mon_owner = i;
        end
        wr_cnt[mon_owner]++;
        vectors++;
        assert (exp_q.size() != 0) else begin
          miscompares++;
          $error("FAIL unexpected_write: observed owner %0d data %h expected no write",
                 mon_owner, fifo_data_in);
        end
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          vectors++;
          assert ({8'(mon_owner), fifo_data_in} === mon_exp) else begin
            miscompares++;
            $error("FAIL write: observed %h expected %h", {8'(mon_owner), fifo_data_in}, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] oh;
    for (int i = 0; i < N; i++) begin
      exp_cnt[i] = 0;
      wr_cnt[i]  = 0;
      ack_cnt[i] = 0;
    end

    // Reset state, before any clock edge.
    #2;
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_wen", 32'(fifo_write_en), 32'h0);
    #10;
    reset_n = 1'b1;

    // Single requester 0: 1-clk grant latency, back-to-back 4-beat bursts.
    step(4'b0001, 1'b0, 4'b0000, 4'b0000);
    for (int s = 0; s < 8; s++) step(4'b0001, 1'b0, 4'b0001, 4'b0001);
    step(4'b0000, 1'b0, 4'b0001, 4'b0000);
    step(4'b0000, 1'b0, 4'b0000, 4'b0000);

    // All requesting: owners 0,1,2,3,0 with four beats each.
    pulse_reset();
    step(4'b1111, 1'b0, 4'b0000, 4'b0000);
    for (int s = 0; s < 20; s++) begin
      oh = 4'(1 << ((s / 4) % 4));
      step(4'b1111, 1'b0, oh, oh);
    end
    step(4'b0000, 1'b0, 4'b0010, 4'b0000);
    step(4'b0000, 1'b0, 4'b0000, 4'b0000);

    // Owner 1 stalled by fifo_full at beat_cnt=2, then exactly 2 more beats.
    step(4'b0010, 1'b0, 4'b0000, 4'b0000);
    step(4'b0010, 1'b0, 4'b0010, 4'b0010);
    step(4'b0010, 1'b0, 4'b0010, 4'b0010);
    for (int s = 0; s < 5; s++) step(4'b0010, 1'b1, 4'b0010, 4'b0000);
    step(4'b0010, 1'b0, 4'b0010, 4'b0010);
    step(4'b1010, 1'b0, 4'b0010, 4'b0010);
    step(4'b0000, 1'b0, 4'b1000, 4'b0000);
    step(4'b0000, 1'b0, 4'b0000, 4'b0000);

    // Owner 0 drops after one beat: hand-over to 2 with no idle cycle.
    step(4'b0101, 1'b0, 4'b0000, 4'b0000);
    step(4'b0101, 1'b0, 4'b0001, 4'b0001);
    step(4'b0100, 1'b0, 4'b0001, 4'b0000);
    step(4'b0100, 1'b0, 4'b0100, 4'b0100);
    step(4'b0000, 1'b0, 4'b0100, 4'b0000);
    step(4'b0000, 1'b0, 4'b0000, 4'b0000);

    // Asynchronous reset in the middle of owner 2's burst.
    step(4'b0100, 1'b0, 4'b0000, 4'b0000);
    step(4'b0100, 1'b0, 4'b0100, 4'b0100);
    step(4'b0100, 1'b0, 4'b0100, 4'b0100);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'h0);
    chk("async_wen", 32'(fifo_write_en), 32'h0);
    chk("async_ack", 32'(ack), 32'h0);
    chk("async_busy", 32'(busy), 32'h0);
    req = '0;
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    step(4'b1100, 1'b0, 4'b0000, 4'b0000);
    step(4'b1100, 1'b0, 4'b0100, 4'b0100);
    step(4'b0000, 1'b0, 4'b0100, 4'b0000);
    step(4'b0000, 1'b0, 4'b0000, 4'b0000);

    // Scoreboard totals.
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    for (int i = 0; i < N; i++) begin
      chk("writes_vs_expected", 32'(wr_cnt[i]), 32'(exp_cnt[i]));
      chk("writes_vs_acks", 32'(wr_cnt[i]), 32'(ack_cnt[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 1, is the data width per requester and equals the shared FIFO data width.
REQ-002 Parameter NREQ, default 4, is the number of requesters, in the range 2..8.
REQ-003 Parameter MAX_BURST, default 4, is the maximum number of accepted beats per grant, in the range 1..15.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 req  input  NREQ  per-requester write request; bit i belongs to requester i.
REQ-008 data  input  NREQ*WIDTH  requester i data on bits [i*WIDTH +: WIDTH].
REQ-009 fifo_full  input  1  full flag from the shared FIFO.
REQ-010 grant  output  NREQ  registered one-hot (or zero) ownership vector.
REQ-011 ack  output  NREQ  combinational beat-accepted strobe per requester.
REQ-012 fifo_write_en  output  1  combinational write enable to the FIFO.
REQ-013 fifo_data_in  output  WIDTH  combinational write data to the FIFO.
REQ-014 busy  output  1  registered; high while in state GRANT.

Function
REQ-015 State machine SHALL have two states: IDLE (grant=0) and GRANT (exactly one grant bit set).
REQ-016 ack[i] SHALL equal grant[i] & req[i] & ~fifo_full; fifo_write_en SHALL equal |ack.
REQ-017 fifo_data_in SHALL equal the data slice of the granted requester, and SHALL be 0 when grant=0.
REQ-018 IDLE -> GRANT on the first edge where |req=1; the owner is the first requesting index searched from (last+1) mod NREQ upward, where last is the most recent owner.
REQ-019 Latency from req rising in IDLE to grant SHALL be 1 clock; the first ack can occur in that grant cycle.
REQ-020 beat_cnt (4 bits) SHALL increment on each ack, and SHALL load 0 on every new grant.
REQ-021 Release occurs at the edge where either (a) the owner's req=0, or (b) an ack occurs with beat_cnt == MAX_BURST-1.
REQ-022 On release, if any req is pending, the FSM SHALL stay in GRANT and the new owner SHALL be chosen by the REQ-018 search starting after the released owner, with no idle bubble. The released owner is eligible only if it is the sole requester.
REQ-023 On release with no req pending, the FSM SHALL go to IDLE, and last SHALL equal the released owner.
REQ-024 fifo_full=1 stalls the burst: ack=0, beat_cnt held, grant held; release by rule (a) still applies.
REQ-025 A requester that drops req and re-raises it later SHALL wait for its round-robin turn.
REQ-026 Beats are never lost or duplicated: each ack equals exactly one FIFO write of that requester's data.

Reset
REQ-027 While reset_n=0, independent of clk: state=IDLE, grant=0, busy=0, beat_cnt=0, last=NREQ-1 (requester 0 highest priority after reset).
REQ-028 Reset asserted mid-burst SHALL drop grant and busy immediately; no partial write occurs, because the combinational outputs follow grant=0.
REQ-029 Reset deassertion SHALL be synchronized externally; the block requires no cycles after reset before accepting req.

Structure
REQ-030 The state encoding (IDLE/GRANT) and the beat_cnt width constant SHALL live in a shared package arb_pkg.
REQ-031 The round-robin search SHALL be one sub-module, rr_pick (inputs req, last; output one-hot pick, valid), reused by later arbiters.
REQ-032 The block SHALL contain no FIFO storage; it connects to the shared FIFO's write_en, data_in and full ports only.

Verification
REQ-033 Reset, then req=4'b0001 held, MAX_BURST=4 -> grant=0001 after 1 clk; 4 acks; a 1-clk re-grant to 0001; the pattern continues.
REQ-034 req=4'b1111 held, FIFO never full -> owners cycle 0,1,2,3,0, with 4 writes each and fifo_data_in matching the owner's data.
REQ-035 Owner 1 in mid-burst with beat_cnt=2, fifo_full=1 for 5 clks -> ack=0 and beat_cnt=2 held; after full drops, 2 more acks then release.
REQ-036 req=4'b0101 with owner 0, then req[0] drops after 1 beat -> next edge grant=0100, with no IDLE cycle.
REQ-037 reset_n pulsed low mid-burst (owner 2) -> grant=0 and fifo_write_en=0 without a clock edge; after release, req=4'b1100 -> grant=0100.
REQ-038 Scoreboard all runs: FIFO write count per requester equals the ack count, and grant is never multi-hot.
